arithmetic_logic_unit: RTL and testbench
========================================

// Module: arithmetic_logic_unit
// PURPOSE
//  Combinational 16-bit ALU with a clocked 4-bit flag register {Z,C,N,O}.
//  FunSel[4] selects width (0: 8-bit on A[7:0]/B[7:0], 1: 16-bit); FunSel[3:0] selects the op.
//  Sits in the datapath between the register-file/address-register read buses and the ALU output mux.
//  The flag carry feeds back into add-with-carry.
// PARAMETERS
//  none (widths fixed: data 16, flags 4)
// PORTS
//  Clock     in   1   system clock, flags update on rising edge
//  Reset     in   1   asynchronous, active-low; clears FlagsOut
//  A         in   16  operand A
//  B         in   16  operand B
//  FunSel    in   5   [4]=width select, [3:0]=operation
//  WF        in   1   write-flags enable
//  ALUOut    out  16  combinational result
//  FlagsOut  out  4   registered flags {Z,C,N,O}; must be a reg declared directly in this
//                     module so benches can force it hierarchically
//  One clock; reset is asynchronous and active-low.
// BEHAVIOUR
//  Op[3:0]: 0 A | 1 B | 2 ~A | 3 ~B | 4 A+B | 5 A+B+C | 6 A-B | 7 A&B | 8 A|B | 9 A^B
//   | A ~(A&B) | B LSL A | C LSR A | D ASR A | E CSL A (rotate left) | F CSR A (rotate right).
//  ALUOut purely combinational from A, B, FunSel and current FlagsOut[C]; zero latency.
//  8-bit mode: compute on low byte; ALUOut = sign-extended 8-bit result ({8{r[7]}},r[7:0]).
//  Z = (result width bits == 0); N = result MSB (bit7 in 8-bit, bit15 in 16-bit).
//  Add: C = carry out of MSB; O = operands same sign, result sign differs.
//  Sub: computed as A + ~B + 1; C = carry out (1 = no borrow, A>=B unsigned);
//   O = operand signs differ and result sign differs from A.
//  Shifts/rotates: C = bit shifted out (MSB for LSL/CSL, LSB for LSR/ASR/CSR); O unchanged.
//  Logic, NOT, pass-through ops: update Z,N only; C,O unchanged.
//  Flags: on rising Clock with WF=1, FlagsOut <= flags computed from pre-edge inputs;
//   WF=0 holds. After the edge ALUOut recomputes with the new C (A+B+C may change).
//  Reset low (any time): FlagsOut <= 4'b0000 immediately; ALUOut unaffected.
// STRUCTURE
//  Shared package: FunSel op-code localparams (OP_A..OP_CSR), flag bit indices (Z=3,C=2,N=1,O=0).
//  One sub-module natural: alu_flag_reg (4-bit async-reset register with write enable);
//   result/flag generation as a single combinational always block.
// TESTING
//  16b add: A=1234,B=4321,Fun=10100,WF=1,flags forced 1111 -> ALUOut 5555, flags 1111 pre-edge, 0000 after edge
//  16b A+B+C: A=7777,B=8889,Fun=10101,flags 0000 -> edge sets Z=1,C=1; ALUOut then 0001
//  16b sub: A=F0CD,B=37FE,Fun=10110 -> B8CF, Z0 C1 N1 O0; A=4E20,B=9E58 -> AFC8, C0 N1 O1
//  8b sub: A=00BD,B=0035,Fun=00110 -> FF88, C1 N1 O0; A=00FD,B=007F -> 007E, C1 N0 O1
//  8b ops: A=00B5 NOT -> 004A flags 0000; A=B=00B5 add-carry, C=0 -> C1 O1, then 006B;
//   A=00A5 LSL (01011) -> 004A, C=1
//  Reset low mid-run with flags 1111 -> FlagsOut 0000 without clock; WF=0 edge -> flags held

Source files
------------

// File: rtl/arithmetic_logic_unit_pkg.sv
// Shared definitions for the 16-bit ALU.
//   - FunSel[3:0] operation codes (OP_A .. OP_CSR)
//   - FunSel[4] width select bit position
//   - Bit positions of the {Z,C,N,O} flags inside FlagsOut
package arithmetic_logic_unit_pkg;

    localparam int DATA_W  = 16;
    localparam int FLAGS_W = 4;

    localparam int FUN_WIDE_BIT = 4;

    localparam logic [3:0] OP_A     = 4'h0;
    localparam logic [3:0] OP_B     = 4'h1;
    localparam logic [3:0] OP_NOT_A = 4'h2;
    localparam logic [3:0] OP_NOT_B = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_ADC   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_NAND  = 4'hA;
    localparam logic [3:0] OP_LSL   = 4'hB;
    localparam logic [3:0] OP_LSR   = 4'hC;
    localparam logic [3:0] OP_ASR   = 4'hD;
    localparam logic [3:0] OP_CSL   = 4'hE;
    localparam logic [3:0] OP_CSR   = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

endpackage

// File: rtl/arithmetic_logic_unit_core.sv
// Combinational result and next-flag generation.
// Ports:
//   a, b        in  16  operands
//   fun_sel     in  5   [4]=width (0: 8-bit on low bytes, 1: 16-bit), [3:0]=op
//   carry_in    in  1   current C flag (used by add-with-carry, held by non-carry ops)
//   ovf_in      in  1   current O flag (held by ops that do not define O)
//   result      out 16  ALU result (8-bit mode: sign-extended low byte)
//   flags_next  out 4   {Z,C,N,O} the flag register loads on a write
module arithmetic_logic_unit_core
    import arithmetic_logic_unit_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [4:0]         fun_sel,
    input  logic               carry_in,
    input  logic               ovf_in,
    output logic [DATA_W-1:0]  result,
    output logic [FLAGS_W-1:0] flags_next
);

    logic              wide;
    logic [3:0]        op;
    logic [3:0]        msb;
    logic [15:0]       top_bit;
    logic [15:0]       a_w;
    logic [15:0]       b_w;
    logic [15:0]       b_inv;
    logic [16:0]       sum;
    logic [15:0]       r;
    logic              carry;
    logic              ovf;
    logic              zero;
    logic              neg;

    always_comb begin
        wide    = fun_sel[FUN_WIDE_BIT];
        op      = fun_sel[3:0];
        msb     = wide ? 4'd15 : 4'd7;
        top_bit = wide ? 16'h8000 : 16'h0080;
        // In 8-bit mode the upper byte is cleared so carries land in bit 8.
        a_w     = wide ? a : {8'h00, a[7:0]};
        b_w     = wide ? b : {8'h00, b[7:0]};
        b_inv   = wide ? ~b : {8'h00, ~b[7:0]};
        sum     = 17'd0;
        r       = 16'd0;
        carry   = carry_in;
        ovf     = ovf_in;

        case (op)
            OP_A:     r = a_w;
            OP_B:     r = b_w;
            OP_NOT_A: r = ~a_w;
            OP_NOT_B: r = ~b_w;
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, a_w} + {1'b0, b_w}
                      + {16'd0, (op == OP_ADC) ? carry_in : 1'b0};
                r     = sum[15:0];
                carry = wide ? sum[16] : sum[8];
                ovf   = (a_w[msb] == b_w[msb]) && (r[msb] != a_w[msb]);
            end
            OP_SUB: begin
                sum   = {1'b0, a_w} + {1'b0, b_inv} + 17'd1;
                r     = sum[15:0];
                carry = wide ? sum[16] : sum[8];
                ovf   = (a_w[msb] != b_w[msb]) && (r[msb] != a_w[msb]);
            end
            OP_AND:   r = a_w & b_w;
            OP_OR:    r = a_w | b_w;
            OP_XOR:   r = a_w ^ b_w;
            OP_NAND:  r = ~(a_w & b_w);
            OP_LSL: begin
                r     = a_w << 1;
                carry = a_w[msb];
            end
            OP_LSR: begin
                r     = a_w >> 1;
                carry = a_w[0];
            end
            OP_ASR: begin
                r     = (a_w >> 1) | (a_w[msb] ? top_bit : 16'h0000);
                carry = a_w[0];
            end
            OP_CSL: begin
                r     = (a_w << 1) | {15'd0, a_w[msb]};
                carry = a_w[msb];
            end
            OP_CSR: begin
                r     = (a_w >> 1) | (a_w[0] ? top_bit : 16'h0000);
                carry = a_w[0];
            end
            default: r = a_w;
        endcase

        result = wide ? r : {{8{r[7]}}, r[7:0]};
        zero   = wide ? (r == 16'd0) : (r[7:0] == 8'd0);
        neg    = r[msb];

        flags_next         = '0;
        flags_next[FLAG_Z] = zero;
        flags_next[FLAG_C] = carry;
        flags_next[FLAG_N] = neg;
        flags_next[FLAG_O] = ovf;
    end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// 16-bit ALU with a clocked {Z,C,N,O} flag register.
// Ports:
//   Clock     in  1   flags update on rising edge
//   Reset     in  1   asynchronous, active-low; clears FlagsOut only
//   A, B      in  16  operands
//   FunSel    in  5   [4]=width select, [3:0]=operation
//   WF        in  1   write-flags enable
//   ALUOut    out 16  combinational result (zero latency)
//   FlagsOut  out 4   registered flags {Z,C,N,O}
// The flag register lives directly in this module so FlagsOut is a plain
// variable that can be forced hierarchically.
module arithmetic_logic_unit
    import arithmetic_logic_unit_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic [DATA_W-1:0]  A,
    input  logic [DATA_W-1:0]  B,
    input  logic [4:0]         FunSel,
    input  logic               WF,
    output logic [DATA_W-1:0]  ALUOut,
    output logic [FLAGS_W-1:0] FlagsOut
);

    logic [FLAGS_W-1:0] flags_next;

    arithmetic_logic_unit_core u_core (
        .a          (A),
        .b          (B),
        .fun_sel    (FunSel),
        .carry_in   (FlagsOut[FLAG_C]),
        .ovf_in     (FlagsOut[FLAG_O]),
        .result     (ALUOut),
        .flags_next (flags_next)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            FlagsOut <= '0;
        end else if (WF) begin
            FlagsOut <= flags_next;
        end
    end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
module tb_arithmetic_logic_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  FunSel;
    logic        WF;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;

    int checks = 0;
    int errors = 0;

    arithmetic_logic_unit dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .FunSel   (FunSel),
        .WF       (WF),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive new inputs mid-low-phase so nothing changes near a rising edge.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [4:0] f, input logic wf);
        @(negedge Clock);
        A = a; B = b; FunSel = f; WF = wf;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; A = 16'h0; B = 16'h0; FunSel = 5'b0; WF = 1'b0;
        #2 Reset = 1'b0;
        #1 check4("reset_flags", FlagsOut, 4'b0000);
        #4 Reset = 1'b1;

        // 16-bit add, flags forced to 1111 beforehand
        drive(16'h1234, 16'h4321, 5'b10100, 1'b1);
        force dut.FlagsOut = 4'b1111;
        #1;
        check16("add16_out", ALUOut, 16'h5555);
        check4("add16_flags_pre", FlagsOut, 4'b1111);
        release dut.FlagsOut;
        edge_settle();
        check4("add16_flags_post", FlagsOut, 4'b0000);

        // 16-bit add with carry: carry feeds back after the edge
        drive(16'h7777, 16'h8889, 5'b10101, 1'b1);
        check16("adc16_out_pre", ALUOut, 16'h0000);
        edge_settle();
        check4("adc16_flags", FlagsOut, 4'b1100);
        check16("adc16_out_post", ALUOut, 16'h0001);

        // 16-bit subtract
        drive(16'hF0CD, 16'h37FE, 5'b10110, 1'b1);
        check16("sub16a_out", ALUOut, 16'hB8CF);
        edge_settle();
        check4("sub16a_flags", FlagsOut, 4'b0110);
        drive(16'h4E20, 16'h9E58, 5'b10110, 1'b1);
        check16("sub16b_out", ALUOut, 16'hAFC8);
        edge_settle();
        check4("sub16b_flags", FlagsOut, 4'b0011);

        // 8-bit subtract
        drive(16'h00BD, 16'h0035, 5'b00110, 1'b1);
        check16("sub8a_out", ALUOut, 16'hFF88);
        edge_settle();
        check4("sub8a_flags", FlagsOut, 4'b0110);
        drive(16'h00FD, 16'h007F, 5'b00110, 1'b1);
        check16("sub8b_out", ALUOut, 16'h007E);
        edge_settle();
        check4("sub8b_flags", FlagsOut, 4'b0101);

        // Clear C and O with a plain add, then 8-bit NOT
        drive(16'h0001, 16'h0001, 5'b10100, 1'b1);
        check16("add16_small_out", ALUOut, 16'h0002);
        edge_settle();
        check4("add16_small_flags", FlagsOut, 4'b0000);
        drive(16'h00B5, 16'h0000, 5'b00010, 1'b1);
        check16("not8_out", ALUOut, 16'h004A);
        edge_settle();
        check4("not8_flags", FlagsOut, 4'b0000);

        // 8-bit add with carry, C=0 then result picks up new C
        drive(16'h00B5, 16'h00B5, 5'b00101, 1'b1);
        check16("adc8_out_pre", ALUOut, 16'h006A);
        edge_settle();
        check4("adc8_flags", FlagsOut, 4'b0101);
        check16("adc8_out_post", ALUOut, 16'h006B);

        // Shifts and rotates (O carried over)
        drive(16'h00A5, 16'h0000, 5'b01011, 1'b1);
        check16("lsl8_out", ALUOut, 16'h004A);
        edge_settle();
        check4("lsl8_flags", FlagsOut, 4'b0101);
        drive(16'h8001, 16'h0000, 5'b11101, 1'b1);
        check16("asr16_out", ALUOut, 16'hC000);
        edge_settle();
        check4("asr16_flags", FlagsOut, 4'b0111);
        drive(16'h0081, 16'h0000, 5'b01110, 1'b1);
        check16("csl8_out", ALUOut, 16'h0003);
        edge_settle();
        check4("csl8_flags", FlagsOut, 4'b0101);
        drive(16'h0002, 16'h0000, 5'b11111, 1'b1);
        check16("csr16_out", ALUOut, 16'h0001);
        edge_settle();
        check4("csr16_flags", FlagsOut, 4'b0001);

        // WF=0 holds flags across an edge
        drive(16'h0000, 16'h0080, 5'b00001, 1'b0);
        check16("passb8_out", ALUOut, 16'hFF80);
        edge_settle();
        check4("wf0_hold", FlagsOut, 4'b0001);

        // Asynchronous reset mid-cycle, ALUOut unaffected
        drive(16'h1234, 16'h0000, 5'b10000, 1'b0);
        force dut.FlagsOut = 4'b1111;
        #1;
        check4("force_flags", FlagsOut, 4'b1111);
        release dut.FlagsOut;
        Reset = 1'b0;
        #1;
        check4("async_reset_flags", FlagsOut, 4'b0000);
        check16("async_reset_out", ALUOut, 16'h1234);
        Reset = 1'b1;
        edge_settle();
        check4("post_reset_hold", FlagsOut, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
